// File: rtl/nexys_starship_pkg.sv
// Shared constants for the starship shield-break initiator: side codes,
// one-hot FSM states and the Galois LFSR feedback mask.
package nexys_starship_pkg;

    localparam logic [1:0] SIDE_TOP    = 2'b00;
    localparam logic [1:0] SIDE_BOTTOM = 2'b01;
    localparam logic [1:0] SIDE_LEFT   = 2'b10;
    localparam logic [1:0] SIDE_RIGHT  = 2'b11;

    localparam logic [3:0] IDLE  = 4'b0001;
    localparam logic [3:0] ARMED = 4'b0010;
    localparam logic [3:0] FIRE  = 4'b0100;
    localparam logic [3:0] COOL  = 4'b1000;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Right-shifting Galois step, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Galois LFSR; loads the seed on reset and shifts every clock.
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= seed;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/nexys_starship_break_gen.sv
// Shield-break initiator: paces break requests off timer_clk ticks and picks a
// non-broken side plus a repair combo. Optional macro: DIFFICULTY_RAMP_EN.
module nexys_starship_break_gen
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned MIN_INTERVAL = 2,
    parameter int unsigned COOLDOWN     = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       timer_clk,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic       top_broken,
    input  logic       bottom_broken,
    input  logic       left_broken,
    input  logic       right_broken,
    output logic       TR_random,
    output logic       BR_random,
    output logic       LR_random,
    output logic       RR_random,
    output logic [3:0] random_hex,
    output logic [7:0] fire_count
);

    localparam logic [4:0] COOL_TICKS = 5'(COOLDOWN);

    logic [15:0] lfsr;
    logic        sync_q, sync_qq, tick;
    logic [3:0]  state;
    logic [4:0]  count, interval;
    logic [4:0]  interval_base, interval_next;
    logic [3:0]  pulse, broken;
    logic [1:0]  cand, side;
    logic        found;
    logic [3:0]  hex_next;
    logic        unused_lfsr_bits;

    nexys_starship_lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    assign unused_lfsr_bits = ^{lfsr[15:12], lfsr[7:6], lfsr[3:2]};

    assign tick   = sync_q & ~sync_qq;
    assign broken = {right_broken, left_broken, bottom_broken, top_broken};

    assign interval_base = 5'(MIN_INTERVAL) + {3'b000, lfsr[5:4]};
`ifdef DIFFICULTY_RAMP_EN
    // Pacing tightens one tick per 8 fires, never below one tick.
    assign interval_next = (interval_base > fire_count[7:3]) ?
                           interval_base - fire_count[7:3] : 5'd1;
`else
    assign interval_next = interval_base;
`endif

    assign hex_next = (lfsr[11:8] == 4'h0) ? 4'hF : lfsr[11:8];

    // Rotate from the LFSR candidate to the first side that is still intact.
    always_comb begin
        found = 1'b0;
        side  = lfsr[1:0];
        cand  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = lfsr[1:0] + 2'(i);
            if (!found && !broken[cand]) begin
                found = 1'b1;
                side  = cand;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q     <= 1'b0;
            sync_qq    <= 1'b0;
            state      <= IDLE;
            count      <= '0;
            interval   <= '0;
            pulse      <= '0;
            random_hex <= 4'h1;
            fire_count <= '0;
        end else begin
            sync_q  <= timer_clk;
            sync_qq <= sync_q;
            pulse   <= '0;
            if (gameover_ctrl) begin
                state      <= IDLE;
                count      <= '0;
                fire_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        count      <= '0;
                        fire_count <= '0;
                        if (play_flag) begin
                            state    <= ARMED;
                            interval <= interval_next;
                        end
                    end
                    ARMED: begin
                        if (count == interval) begin
                            state <= FIRE;
                        end else if (tick) begin
                            count <= count + 5'd1;
                        end
                    end
                    FIRE: begin
                        count <= '0;
                        if (found) begin
                            pulse      <= 4'b0001 << side;
                            random_hex <= hex_next;
                            if (fire_count != 8'hFF) begin
                                fire_count <= fire_count + 8'd1;
                            end
                            if (COOLDOWN == 0) begin
                                state    <= ARMED;
                                interval <= interval_next;
                            end else begin
                                state <= COOL;
                            end
                        end else begin
                            state    <= ARMED;
                            interval <= interval_next;
                        end
                    end
                    COOL: begin
                        if (count == COOL_TICKS) begin
                            state    <= ARMED;
                            interval <= interval_next;
                            count    <= '0;
                        end else if (tick) begin
                            count <= count + 5'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    // Game-over kills any pulse in the same cycle it is asserted.
    assign TR_random = pulse[SIDE_TOP]    & ~gameover_ctrl;
    assign BR_random = pulse[SIDE_BOTTOM] & ~gameover_ctrl;
    assign LR_random = pulse[SIDE_LEFT]   & ~gameover_ctrl;
    assign RR_random = pulse[SIDE_RIGHT]  & ~gameover_ctrl;

endmodule

// File: tb/tb_nexys_starship_break_gen.sv
// Self-checking bench for nexys_starship_break_gen against an event-level reference model.
module tb_nexys_starship_break_gen;

    localparam logic [15:0] P_SEED = 16'hACE1;
    localparam int P_MIN  = 2;
    localparam int P_COOL = 1;
`ifdef DIFFICULTY_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, tclk, play, go;
    logic [3:0] brk;
    logic       tr, br, lr, rr;
    logic [3:0] hex;
    logic [7:0] fc;

    nexys_starship_break_gen #(
        .LFSR_SEED    (P_SEED),
        .MIN_INTERVAL (P_MIN),
        .COOLDOWN     (P_COOL)
    ) dut (
        .Clk           (clk),
        .Reset         (rst),
        .timer_clk     (tclk),
        .play_flag     (play),
        .gameover_ctrl (go),
        .top_broken    (brk[0]),
        .bottom_broken (brk[1]),
        .left_broken   (brk[2]),
        .right_broken  (brk[3]),
        .TR_random     (tr),
        .BR_random     (br),
        .LR_random     (lr),
        .RR_random     (rr),
        .random_hex    (hex),
        .fire_count    (fc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef enum {M_IDLE, M_WAIT, M_SHOOT, M_REST} phase_t;
    phase_t      m_phase;
    logic [15:0] m_l;
    logic        m_s1, m_s2;
    int          m_left, m_fc, m_ticks;
    logic [3:0]  m_pulse, m_hex;

    int         pc [4];
    int         pulses;
    logic [3:0] last_obs;
    bit         tc_auto;
    int         tc_hold, tc_lo, tc_hi;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic int ref_interval(input logic [15:0] l, input int fires);
        int base;
        base = P_MIN + int'(l[5:4]);
        if (RAMP) begin
            base = base - fires / 8;
            if (base < 1) base = 1;
        end
        return base;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_l = P_SEED; m_s1 = 0; m_s2 = 0;
        m_left = 0; m_fc = 0; m_pulse = 0; m_hex = 4'h1;
    endtask

    // One clock edge of the game rules, using the inputs present at the edge.
    task automatic model_edge();
        logic        tk;
        logic [15:0] l;
        int          iv, s;
        bit          hit;
        if (rst) begin model_reset(); return; end
        tk = m_s1 & ~m_s2;
        if (tk) m_ticks++;
        l  = m_l;
        iv = ref_interval(l, m_fc);
        m_s2 = m_s1; m_s1 = tclk; m_l = ref_lfsr(l); m_pulse = 0;
        if (go) begin m_phase = M_IDLE; m_fc = 0; return; end
        case (m_phase)
            M_IDLE: begin
                m_fc = 0;
                if (play) begin m_phase = M_WAIT; m_left = iv; end
            end
            M_WAIT: if (m_left == 0) m_phase = M_SHOOT; else if (tk) m_left--;
            M_SHOOT: begin
                hit = 0; s = 0;
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (int'(l[1:0]) + k) % 4;
                    if (!hit && !brk[c]) begin hit = 1; s = c; end
                end
                if (hit) begin
                    m_pulse = 4'(1 << s);
                    m_hex = (l[11:8] == 4'h0) ? 4'hF : l[11:8];
                    if (m_fc < 255) m_fc++;
                    if (P_COOL == 0) begin m_phase = M_WAIT; m_left = iv; end
                    else begin m_phase = M_REST; m_left = P_COOL; end
                end else begin
                    m_phase = M_WAIT; m_left = iv;
                end
            end
            M_REST: if (m_left == 0) begin m_phase = M_WAIT; m_left = iv; end
                    else if (tk) m_left--;
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic cycle();
        logic [3:0] obs;
        @(negedge clk);
        obs = {rr, lr, br, tr};
        chk("pulse", 16'(obs), 16'(m_pulse & ~{4{go}}));
        chk("hex", 16'(hex), 16'(m_hex));
        chk("fire_count", 16'(fc), 16'(m_fc));
        chk("onehot", 16'($countones(obs) <= 1), 16'd1);
        chk("hex_nonzero", 16'(hex != 4'h0), 16'd1);
        for (int i = 0; i < 4; i++) if (obs[i]) pc[i]++;
        if (|obs) pulses++;
        last_obs = obs;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            if (tc_auto) begin
                if (tc_hold == 0) begin
                    tclk = ~tclk;
                    tc_hold = $urandom_range(tc_hi, tc_lo);
                end else tc_hold--;
            end
            cycle();
        end
    endtask

    task automatic wait_pulse(string tag, int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            run(1);
            seen = |last_obs;
        end
        chk(tag, 16'(seen), 16'd1);
    endtask

    initial begin
        int p0, p3, tot, fc_save, t0;
        logic [3:0] hex_save;
        bit reached;

        rst = 1; tclk = 0; play = 0; go = 0; brk = 0;
        tc_auto = 0; tc_hold = 0; tc_lo = 1; tc_hi = 4;
        pulses = 0; last_obs = 0;
        for (int i = 0; i < 4; i++) pc[i] = 0;
        model_reset();
        run(3);
        chk("reset_hex", 16'(hex), 16'h1);
        chk("reset_fc", 16'(fc), 16'h0);
        chk("reset_pulses", 16'({rr, lr, br, tr}), 16'h0);

        // First fire from seed, then a random mix of broken sides.
        rst = 0; play = 1; tc_auto = 1;
        wait_pulse("first_pulse", 400);
        for (int r = 0; r < 30; r++) begin
            brk = 4'($urandom_range(15, 0));
            run(40);
        end

        brk = 4'b1000; p3 = pc[3];
        run(400);
        chk("right_blocked", 16'(pc[3] - p3), 16'd0);
        brk = 4'b1001; p0 = pc[0]; p3 = pc[3];
        run(400);
        chk("top_right_blocked", 16'((pc[0] - p0) + (pc[3] - p3)), 16'd0);

        brk = 4'hF; fc_save = m_fc; hex_save = m_hex; tot = pulses; t0 = m_ticks;
        for (int i = 0; i < 4000 && (m_ticks - t0) < 200; i++) run(1);
        chk("allbroken_ticks", 16'((m_ticks - t0) >= 200), 16'd1);
        chk("allbroken_pulses", 16'(pulses - tot), 16'd0);
        chk("allbroken_fc", 16'(fc), 16'(fc_save));
        chk("allbroken_hex", 16'(hex), 16'(hex_save));
        brk = 4'h0;

        tc_auto = 0; tclk = 1; t0 = m_ticks;
        run(50);
        tclk = 0;
        run(3);
        tc_auto = 1; tc_hold = 0;
        wait_pulse("after_hold", 400);

        // Game-over in the cycle the fire step would be entered.
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            run(1);
            reached = (m_phase == M_WAIT && m_left == 0 && m_fc > 0);
        end
        chk("reach_pre_fire", 16'(reached), 16'd1);
        go = 1;
        run(1);
        go = 0;
        chk("gameover_fc", 16'(fc), 16'd0);
        chk("gameover_nopulse", 16'({rr, lr, br, tr}), 16'd0);
        run(100);

        // Asynchronous reset while cooling down.
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            run(1);
            reached = (m_phase == M_REST);
        end
        chk("reach_cool", 16'(reached), 16'd1);
        @(negedge clk);
        rst = 1;
        model_reset();
        #1;
        chk("midreset_hex", 16'(hex), 16'h1);
        chk("midreset_fc", 16'(fc), 16'h0);
        chk("midreset_pulses", 16'({rr, lr, br, tr}), 16'h0);
        @(posedge clk);
        #1;
        run(2);
        rst = 0; play = 0; tot = pulses;
        run(60);
        chk("idle_no_pulse", 16'(pulses - tot), 16'd0);
        play = 1;
        wait_pulse("pulse_after_reset", 400);

        if (RAMP) begin
            for (int i = 0; i < 20000 && m_fc < 72; i++) run(1);
            chk("ramp_fires", 16'(m_fc >= 72), 16'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
